// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - wraps each payload frame in sof0/sof1/seq header and a trailing mod-256 checksum
// One-entry registered output; ld = ~valid_o | ready_i gates every output-register update.
module uart_tx_framer #(
  parameter int         width_p       = 8,
  parameter int         frame_bytes_p = 76800,
  parameter logic [7:0] sof0_p        = 8'hA5,
  parameter logic [7:0] sof1_p        = 8'h5A
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic [7:0]         frame_seq_o,
  output logic               busy_o
);

  localparam int cnt_w_lp = (frame_bytes_p > 1) ? $clog2(frame_bytes_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(frame_bytes_p - 1);

  typedef enum logic [2:0] {IDLE, SOF1, SEQ, PAYLOAD, CSUM} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [width_p-1:0]  data_q,  data_d;
  logic [7:0]          seq_q,   seq_d;
  logic [7:0]          csum_q,  csum_d;
  logic [cnt_w_lp-1:0] cnt_q,   cnt_d;

  logic ld;
  logic accept;
  logic last_byte;

  assign ld        = ~valid_q | ready_i;
  assign accept    = (state_q == PAYLOAD) & ld & valid_i;
  assign last_byte = (cnt_q == last_cnt_lp);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      seq_q   <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld && valid_i)      state_d = SOF1;
      SOF1:    if (ld)                 state_d = SEQ;
      SEQ:     if (ld)                 state_d = PAYLOAD;
      PAYLOAD: if (accept && last_byte) state_d = CSUM;
      CSUM:    if (ld)                 state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Header loads never consume a payload byte; only PAYLOAD raises ready_o.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    ready_o = 1'b0;
    busy_o  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (ld) begin
          valid_d = valid_i;
          if (valid_i) data_d = width_p'(sof0_p);
        end
      end
      SOF1: begin
        if (ld) begin
          valid_d = 1'b1;
          data_d  = width_p'(sof1_p);
        end
      end
      SEQ: begin
        if (ld) begin
          valid_d = 1'b1;
          data_d  = width_p'(seq_q);
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      PAYLOAD: begin
        ready_o = ld;
        if (ld) valid_d = valid_i;
        if (accept) begin
          data_d = data_i;
          csum_d = csum_q + 8'(data_i);
          cnt_d  = last_byte ? '0 : cnt_q + cnt_w_lp'(1);
        end
      end
      CSUM: begin
        if (ld) begin
          valid_d = 1'b1;
          data_d  = width_p'(csum_q);
          seq_d   = seq_q + 8'd1;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_seq_o = seq_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer (4-byte and 1-byte frames)
module tb_uart_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       ready_o, valid_i, valid_o, busy_o;
  logic       ready_i = 1'b1;
  logic [7:0] data_i, data_o, frame_seq_o;

  logic       b_ready_o, b_valid_i, b_ready_i, b_valid_o, b_busy_o;
  logic [7:0] b_data_i, b_data_o, b_seq_o;

  uart_tx_framer #(.width_p(8), .frame_bytes_p(4)) dut (
    .clk_i(clk), .reset_i(reset_n),
    .ready_o(ready_o), .valid_i(valid_i), .data_i(data_i),
    .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o),
    .frame_seq_o(frame_seq_o), .busy_o(busy_o)
  );

  uart_tx_framer #(.width_p(8), .frame_bytes_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_n),
    .ready_o(b_ready_o), .valid_i(b_valid_i), .data_i(b_data_i),
    .ready_i(b_ready_i), .valid_o(b_valid_o), .data_o(b_data_o),
    .frame_seq_o(b_seq_o), .busy_o(b_busy_o)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  int         seq_m = 0;
  bit         rand_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: pops one expected byte per downstream handshake and checks hold-while-stalled.
  bit         stall_p = 0;
  logic [7:0] stall_data;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_p = 0;
    end else begin
      if (stall_p) begin
        check("stall_valid", valid_o, 1);
        check("stall_data", data_o, stall_data);
      end
      if (valid_o && ready_i) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check("byte", data_o, sb.pop_front());
      end
      stall_p    = valid_o && !ready_i;
      stall_data = data_o;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit acc;
    acc   = 0;
    waits = 0;
    valid_i = 1'b1;
    data_i  = b;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #2;
      if (!acc) waits++;
    end
    check("send_accept", acc, 1);
    valid_i = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] p[4]);
    logic [7:0] cs;
    cs = 8'h00;
    sb.push_back(8'hA5);
    sb.push_back(8'h5A);
    sb.push_back(8'(seq_m));
    for (int i = 0; i < 4; i++) begin
      sb.push_back(p[i]);
      cs = cs + p[i];
    end
    sb.push_back(cs);
    seq_m = (seq_m + 1) % 256;
  endtask

  task automatic send_frame(input logic [7:0] p[4], input int max_gap, output int first_waits);
    int w;
    first_waits = 0;
    push_frame(p);
    for (int i = 0; i < 4; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #0;
      send_byte(p[i], w);
      if (i == 0) first_waits = w;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] f[4];
    logic [7:0] bq[$];
    logic [7:0] bgot[$];
    int         w;
    int         b_acc;
    int         n;

    reset_n   = 1'b0;
    valid_i   = 1'b0;
    data_i    = 8'h00;
    b_valid_i = 1'b0;
    b_ready_i = 1'b1;
    b_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_seq", frame_seq_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", ready_o, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    f = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(f, 0, w);
    check("hdr_backpressure_waits", w, 3);
    drain("drain_f1");
    check("seq_after_f1", frame_seq_o, 1);
    check("idle_busy", busy_o, 0);

    f = '{8'hFF, 8'hFF, 8'hFF, 8'h03};
    send_frame(f, 0, w);
    f = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(f, 0, w);
    drain("drain_f23");
    check("seq_after_f3", frame_seq_o, 3);

    rand_mode = 1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++) f[i] = 8'($urandom);
      send_frame(f, 2, w);
    end
    rand_mode = 0;
    drain("drain_rand");
    check("seq_after_rand", frame_seq_o, 32'(seq_m));

    f = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_frame(f);
    send_byte(8'h11, w);
    send_byte(8'h22, w);
    check("mid_busy", busy_o, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_seq", frame_seq_o, 0);
    sb.delete();
    seq_m = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    f = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(f, 0, w);
    drain("drain_after_rst");
    check("seq_after_rst", frame_seq_o, 1);

    bq = '{8'hA5, 8'h5A, 8'h00, 8'h7E, 8'h7E};
    b_acc     = 0;
    b_data_i  = 8'h7E;
    b_valid_i = 1'b1;
    n = 0;
    while (bgot.size() < 5 && n < 60) begin
      @(negedge clk);
      if (b_valid_i && b_ready_o) b_acc++;
      if (b_valid_o && b_ready_i) bgot.push_back(b_data_o);
      @(posedge clk);
      #2;
      if (b_acc != 0) b_valid_i = 1'b0;
      n++;
    end
    check("b_count", bgot.size(), 5);
    while (bq.size() != 0 && bgot.size() != 0) check("b_byte", bgot.pop_front(), bq.pop_front());
    check("b_accepts", b_acc, 1);
    check("b_seq", b_seq_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
